// File: rtl/ex_issue_reg.sv
`default_nettype none
// ============================================================================
// ex_issue_reg : ID/EX register - ALU control decode, operand B select, valid/ready
// Revision     : 1.0
// ============================================================================
module ex_issue_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op_class,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            alu_src,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_ina,
  output logic [XLEN-1:0] alu_inb,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic            branch_out,
  output logic            illegal_op
);

  localparam logic [3:0] c_alu_add = 4'b0010;
  localparam logic [3:0] c_alu_sub = 4'b0110;
  localparam logic [3:0] c_alu_and = 4'b0000;
  localparam logic [3:0] c_alu_or  = 4'b0001;

  logic [3:0]      w_alu_ctrl;
  logic            w_illegal;
  logic [XLEN-1:0] w_inb;
  logic            w_capture;

  logic            r_valid;
  logic [3:0]      r_alu_ctrl;
  logic [XLEN-1:0] r_ina;
  logic [XLEN-1:0] r_inb;
  logic [XLEN-1:0] r_store_data;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_branch;
  logic            r_illegal;

  always_comb begin
    w_alu_ctrl = c_alu_add;
    w_illegal  = 1'b0;
    case (alu_op_class)
      2'b00: w_alu_ctrl = c_alu_add;
      2'b01: w_alu_ctrl = c_alu_sub;
      2'b10: begin
        case (funct3)
          3'b000:  w_alu_ctrl = funct7_5 ? c_alu_sub : c_alu_add;
          3'b111:  w_alu_ctrl = c_alu_and;
          3'b110:  w_alu_ctrl = c_alu_or;
          default: w_illegal  = 1'b1;
        endcase
      end
      default: begin
        // I-type: funct7_5 is immediate bits, not an opcode modifier
        case (funct3)
          3'b000:  w_alu_ctrl = c_alu_add;
          3'b111:  w_alu_ctrl = c_alu_and;
          3'b110:  w_alu_ctrl = c_alu_or;
          default: w_illegal  = 1'b1;
        endcase
      end
    endcase
  end

  assign w_inb     = alu_src ? imm : rs2_data;
  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_alu_ctrl   <= 4'b0000;
      r_ina        <= '0;
      r_inb        <= '0;
      r_store_data <= '0;
      r_rd         <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      // Payload only moves on capture so stalled outputs stay bit-stable
      if (w_capture) begin
        r_alu_ctrl   <= w_alu_ctrl;
        r_ina        <= rs1_data;
        r_inb        <= w_inb;
        r_store_data <= rs2_data;
        r_rd         <= rd;
        r_reg_write  <= reg_write && !w_illegal;
        r_mem_read   <= mem_read;
        r_mem_write  <= mem_write && !w_illegal;
        r_branch     <= branch;
        r_illegal    <= w_illegal;
      end
    end
  end

  assign out_valid     = r_valid;
  assign alu_ctrl      = r_alu_ctrl;
  assign alu_ina       = r_ina;
  assign alu_inb       = r_inb;
  assign store_data    = r_store_data;
  assign rd_out        = r_rd;
  assign reg_write_out = r_reg_write;
  assign mem_read_out  = r_mem_read;
  assign mem_write_out = r_mem_write;
  assign branch_out    = r_branch;
  assign illegal_op    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ex_issue_reg.sv
`default_nettype none
// tb_ex_issue_reg : directed + random stimulus, queue scoreboard with a decoupled monitor.
module tb_ex_issue_reg;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op_class = 2'b00;
  logic [2:0]      funct3 = 3'b000;
  logic            funct7_5 = 1'b0;
  logic            alu_src = 1'b0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [XLEN-1:0] imm = '0;
  logic [4:0]      rd = 5'd0;
  logic            reg_write = 1'b0;
  logic            mem_read = 1'b0;
  logic            mem_write = 1'b0;
  logic            branch = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_ina;
  logic [XLEN-1:0] alu_inb;
  logic [XLEN-1:0] store_data;
  logic [4:0]      rd_out;
  logic            reg_write_out;
  logic            mem_read_out;
  logic            mem_write_out;
  logic            branch_out;
  logic            illegal_op;

  ex_issue_reg #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op_class(alu_op_class), .funct3(funct3), .funct7_5(funct7_5), .alu_src(alu_src),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .alu_ina(alu_ina), .alu_inb(alu_inb), .store_data(store_data), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .branch_out(branch_out), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            iv, ordy, fl;
    logic [1:0]      cls;
    logic [2:0]      f3;
    logic            f75, src;
    logic [XLEN-1:0] a, b, im;
    logic [4:0]      rd;
    logic            rw, mr, mw, br;
  } stim_t;

  typedef struct {
    logic [3:0]      ctrl;
    logic            ill;
    logic [XLEN-1:0] ina, inb, sd;
    logic [4:0]      rd;
    logic            rw, mr, mw, br;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: ALU code and legality straight from the opcode-class table
  function automatic exp_t model(input stim_t s);
    exp_t e;
    e.ill = 1'b0;
    if (s.cls == 2'b00)      e.ctrl = 4'b0010;
    else if (s.cls == 2'b01) e.ctrl = 4'b0110;
    else if (s.f3 == 3'b111) e.ctrl = 4'b0000;
    else if (s.f3 == 3'b110) e.ctrl = 4'b0001;
    else if (s.f3 == 3'b000) e.ctrl = (s.cls == 2'b10 && s.f75) ? 4'b0110 : 4'b0010;
    else begin
      e.ctrl = 4'b0010;
      e.ill  = 1'b1;
    end
    e.ina = s.a;
    e.inb = s.src ? s.im : s.b;
    e.sd  = s.b;
    e.rd  = s.rd;
    e.rw  = s.rw & ~e.ill;
    e.mr  = s.mr;
    e.mw  = s.mw & ~e.ill;
    e.br  = s.br;
    return e;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    logic [1:0] pick;
    s.iv   = ($urandom_range(0, 3) != 0);
    s.ordy = ($urandom_range(0, 9) < 7);
    s.fl   = ($urandom_range(0, 9) == 0);
    s.cls  = 2'($urandom_range(0, 3));
    pick   = 2'($urandom_range(0, 3));
    s.f3   = (pick == 2'd0) ? 3'b000 : (pick == 2'd1) ? 3'b111 :
             (pick == 2'd2) ? 3'b110 : 3'($urandom_range(0, 7));
    s.f75  = 1'($urandom_range(0, 1));
    s.src  = 1'($urandom_range(0, 1));
    s.a    = $urandom;
    s.b    = $urandom;
    s.im   = $urandom;
    s.rd   = 5'($urandom_range(0, 31));
    s.rw   = 1'($urandom_range(0, 1));
    s.mr   = 1'($urandom_range(0, 1));
    s.mw   = 1'($urandom_range(0, 1));
    s.br   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Applies one cycle of stimulus; the stage is empty after the monitor's pop iff it can accept
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    in_valid = s.iv; out_ready = s.ordy; flush = s.fl;
    alu_op_class = s.cls; funct3 = s.f3; funct7_5 = s.f75; alu_src = s.src;
    rs1_data = s.a; rs2_data = s.b; imm = s.im; rd = s.rd;
    reg_write = s.rw; mem_read = s.mr; mem_write = s.mw; branch = s.br;
    @(negedge clk);
    #1;
    if (s.iv && !s.fl && exp_q.size() == 0) exp_q.push_back(model(s));
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 0);
    chk("rst_alu_ina", alu_ina, 0);
    chk("rst_alu_inb", alu_inb, 0);
    chk("rst_store_data", store_data, 0);
    chk("rst_ctrl_bits", {25'd0, rd_out, reg_write_out, mem_read_out, mem_write_out, branch_out, illegal_op}, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() == 0) || out_ready});
      if (exp_q.size() != 0) begin
        if (out_valid) begin
          chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, exp_q[0].ctrl});
          chk("alu_ina", alu_ina, exp_q[0].ina);
          chk("alu_inb", alu_inb, exp_q[0].inb);
          chk("store_data", store_data, exp_q[0].sd);
          chk("rd_out", {27'd0, rd_out}, {27'd0, exp_q[0].rd});
          chk("ctrl_bits", {27'd0, reg_write_out, mem_read_out, mem_write_out, branch_out, illegal_op},
              {27'd0, exp_q[0].rw, exp_q[0].mr, exp_q[0].mw, exp_q[0].br, exp_q[0].ill});
        end
        if (out_ready || flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    stim_t s;
    #2;
    check_reset_values();
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Decode sweep, then an illegal R-type with write enables set
    s = rnd(); s.iv = 1; s.ordy = 1; s.fl = 0;
    s.cls = 2'b10; s.f3 = 3'b000; s.f75 = 1; s.src = 0; s.a = 7; s.b = 3;
    drive(s);
    s.cls = 2'b11; s.f3 = 3'b110; s.src = 1; s.im = 32'h0000_00F0;
    drive(s);
    s.cls = 2'b00; drive(s);
    s.cls = 2'b01; drive(s);
    s.cls = 2'b10; s.f3 = 3'b001; s.rw = 1; s.mw = 1; drive(s);

    // Stall for 3 cycles with new work offered, then release
    s = rnd(); s.iv = 1; s.ordy = 1; s.fl = 0; drive(s);
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.iv = 1; s.ordy = 0; s.fl = 0; drive(s);
    end
    s = rnd(); s.iv = 1; s.ordy = 1; s.fl = 0; drive(s);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      s = rnd(); s.iv = 1; s.ordy = 1; s.fl = 0; drive(s);
    end

    // Flush a held instruction while a new one is offered
    s = rnd(); s.iv = 1; s.ordy = 0; s.fl = 0; drive(s);
    s = rnd(); s.iv = 1; s.ordy = 0; s.fl = 1; drive(s);
    for (int i = 0; i < 2; i++) begin
      s = rnd(); s.iv = 0; s.ordy = 1; s.fl = 0; drive(s);
    end

    // Asynchronous reset mid-stall
    s = rnd(); s.iv = 1; s.ordy = 1; s.fl = 0; drive(s);
    s = rnd(); s.iv = 0; s.ordy = 0; s.fl = 0; drive(s);
    @(posedge clk);
    #3;
    chk("pre_reset_valid", {31'd0, out_valid}, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) drive(rnd());
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.iv = 0; s.ordy = 1; s.fl = 0; drive(s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
